// File: rtl/jk_drive_seq.sv
// ---------------------------------------------------------------------------
// jk_drive_seq
//
// Upstream command sequencer for a JK flip-flop stage. A handshaked command
// (operation + length) is turned into a timed j/k drive. While the drive runs,
// the block keeps its own model of the flip-flop's q. It compares that model
// against the stage's q feedback and records any disagreement in a sticky
// error flag.
//
// Ports
//   clk        in   1      single clock, all state changes on posedge
//   rst        in   1      asynchronous, active-low reset
//   cmd_valid  in   1      command request, held by source until accepted
//   cmd_ready  out  1      block is idle and can accept a command
//   cmd_op     in   2      {j,k}: 00 hold, 01 clear, 10 set, 11 toggle
//   cmd_len    in   LEN_W  drive length in cycles, 0 means 2^LEN_W
//   q_fb       in   1      q output of the driven JK flip-flop
//   j, k       out  1      drive to the flip-flop (only non-zero in DRIVE)
//   busy       out  1      high in DRIVE or CHECK
//   done       out  1      one-cycle pulse during the CHECK cycle
//   exp_q      out  1      modelled (expected) flip-flop q
//   err        out  1      sticky q_fb / exp_q mismatch flag
// ---------------------------------------------------------------------------
module jk_drive_seq #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             exp_q,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_CHECK = 2'b10
  } state_t;

  // The counter is one bit wider than cmd_len so that a length of 2^LEN_W
  // (encoded as cmd_len == 0) can be held without wrapping.
  localparam logic [LEN_W:0] CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0] CNT_FULL = {1'b1, {LEN_W{1'b0}}};

  state_t         state_q,  state_d;
  logic [1:0]     op_q,     op_d;
  logic [LEN_W:0] cnt_q,    cnt_d;
  logic           expq_q,   expq_d;
  logic           chk_en_q, chk_en_d;
  logic           err_q,    err_d;
  logic           cmp_act_s;

  // Next value of a JK flip-flop for a given {j,k} drive.
  function automatic logic jk_next(input logic q_cur, input logic [1:0] jk_in);
    logic q_nxt;
    case (jk_in)
      2'b00:   q_nxt = q_cur;
      2'b01:   q_nxt = 1'b0;
      2'b10:   q_nxt = 1'b1;
      2'b11:   q_nxt = ~q_cur;
      default: q_nxt = q_cur;
    endcase
    return q_nxt;
  endfunction

  // Convert a raw command length into the effective cycle count.
  function automatic logic [LEN_W:0] eff_len(input logic [LEN_W-1:0] len_in);
    logic [LEN_W:0] n;
    if (len_in == {LEN_W{1'b0}}) begin
      n = CNT_FULL;
    end else begin
      n = {1'b0, len_in};
    end
    return n;
  endfunction

  // State, command latch, counter, model and error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'b00;
      cnt_q    <= {(LEN_W + 1){1'b0}};
      expq_q   <= 1'b0;
      chk_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      expq_q   <= expq_d;
      chk_en_q <= chk_en_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: command accept, drive timing, model update and checking.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    expq_d   = expq_q;
    chk_en_d = chk_en_q;
    err_d    = err_q;

    // The first DRIVE edge is skipped: the stage only reflects the first
    // drive after that edge, so q_fb and the model line up from edge two.
    cmp_act_s = ((state_q == ST_DRIVE) && chk_en_q) || (state_q == ST_CHECK);

    if (cmp_act_s && (q_fb != expq_q)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          cnt_d    = eff_len(cmd_len);
          expq_d   = q_fb;
          chk_en_d = 1'b0;
          state_d  = ST_DRIVE;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        expq_d   = jk_next(expq_q, op_q);
        cnt_d    = cnt_q - CNT_ONE;
        chk_en_d = 1'b1;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state; j/k come straight from the op latch.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
    done      = (state_q == ST_CHECK);
    exp_q     = expq_q;
    err       = err_q;
    if (state_q == ST_DRIVE) begin
      j = op_q[1];
      k = op_q[0];
    end else begin
      j = 1'b0;
      k = 1'b0;
    end
  end

endmodule

// File: tb/tb_jk_drive_seq.sv
// ---------------------------------------------------------------------------
// tb_jk_drive_seq
//
// Self-checking bench for jk_drive_seq. The bench attaches a behavioural JK
// flip-flop to j/k and feeds its q back to q_fb. A fault switch can hold
// q_fb at 0. Single-cycle behaviour is checked from a vector table. The
// multi-cycle corner cases are checked with hand-written sequences. Inputs
// change just after a falling edge. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_jk_drive_seq;

  localparam int LEN_W = 4;

  logic             clk       = 1'b0;
  logic             rst       = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op    = 2'b00;
  logic [LEN_W-1:0] cmd_len   = 4'd0;
  logic             q_fb;
  logic             cmd_ready, j, k, busy, done, exp_q, err;

  logic q_ff  = 1'b0;
  logic fault = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  jk_drive_seq #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .q_fb      (q_fb),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .exp_q     (exp_q),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Behavioural JK flip-flop stage, optionally stuck at 0 on its output.
  always @(posedge clk) begin
    case ({j, k})
      2'b01:   q_ff <= 1'b0;
      2'b10:   q_ff <= 1'b1;
      2'b11:   q_ff <= ~q_ff;
      default: q_ff <= q_ff;
    endcase
  end
  assign q_fb = fault ? 1'b0 : q_ff;

  // Outputs packed as {cmd_ready, j, k, busy, done, exp_q, err}.
  typedef struct {
    logic             v;
    logic [1:0]       op;
    logic [LEN_W-1:0] len;
    logic [6:0]       exp;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_chk++;
    if (act === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [6:0] outs();
    return {cmd_ready, j, k, busy, done, exp_q, err};
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    int done_cnt;
    int k_cnt;
    int done_at;
    logic [4:0] exp5;

    // set len 3, clear len 1, toggle len 4; op/len noise on idle rows
    tbl[0]  = '{1'b1, 2'b10, 4'd3, 7'b0101000};
    tbl[1]  = '{1'b0, 2'b01, 4'd7, 7'b0101010};
    tbl[2]  = '{1'b0, 2'b11, 4'd0, 7'b0101010};
    tbl[3]  = '{1'b0, 2'b00, 4'd2, 7'b0001110};
    tbl[4]  = '{1'b0, 2'b00, 4'd0, 7'b1000010};
    tbl[5]  = '{1'b1, 2'b01, 4'd1, 7'b0011010};
    tbl[6]  = '{1'b0, 2'b10, 4'd9, 7'b0001100};
    tbl[7]  = '{1'b0, 2'b10, 4'd9, 7'b1000000};
    tbl[8]  = '{1'b1, 2'b11, 4'd4, 7'b0111000};
    tbl[9]  = '{1'b0, 2'b01, 4'd7, 7'b0111010};
    tbl[10] = '{1'b0, 2'b10, 4'd1, 7'b0111000};
    tbl[11] = '{1'b0, 2'b00, 4'd0, 7'b0111010};
    tbl[12] = '{1'b0, 2'b00, 4'd0, 7'b0001100};
    tbl[13] = '{1'b0, 2'b00, 4'd0, 7'b1000000};

    // Reset held: idle, ready, everything cleared.
    @(negedge clk);
    @(negedge clk);
    check("reset_held", {1'b0, outs()}, {1'b0, 7'b1000000});
    rst = 1'b1;
    step();
    check("reset_release", {1'b0, outs()}, {1'b0, 7'b1000000});

    // Table-driven single-cycle checks.
    for (int i = 0; i < 14; i++) begin
      cmd_valid = tbl[i].v;
      cmd_op    = tbl[i].op;
      cmd_len   = tbl[i].len;
      step();
      check($sformatf("vec%0d", i), {1'b0, outs()}, {1'b0, tbl[i].exp});
    end

    // Length zero: 16 drive cycles, 17 busy cycles, one done pulse.
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = 4'd0;
    step();
    cmd_valid = 1'b0;
    busy_cnt = 0; done_cnt = 0; k_cnt = 0; done_at = 0;
    for (int i = 1; i <= 20; i++) begin
      if (busy) busy_cnt++;
      if (k)    k_cnt++;
      if (done) begin
        done_cnt++;
        done_at = i;
      end
      step();
    end
    check("len0_busy", 8'(busy_cnt), 8'd17);
    check("len0_drive", 8'(k_cnt), 8'd16);
    check("len0_done_cnt", 8'(done_cnt), 8'd1);
    check("len0_done_at", 8'(done_at), 8'd17);

    // Fault: q_fb stuck at 0 during a set of length 2.
    fault = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd2;
    step();
    cmd_valid = 1'b0;
    step();
    check("fault_edge1_err", {7'b0, err}, 8'd0);
    step();
    check("fault_edge2", {6'b0, err, done}, 8'b11);
    step();
    fault = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd1;
    step();
    cmd_valid = 1'b0;
    step();
    check("good_cmd_done", {6'b0, done, err}, 8'b11);
    step();
    check("err_sticky", {6'b0, cmd_ready, err}, 8'b11);

    // Busy rejection: second command held until first IDLE cycle after done.
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = 4'd5;
    step();
    cmd_op = 2'b10; cmd_len = 4'd2;
    for (int i = 0; i <= 7; i++) begin
      // {cmd_ready, j, k, busy, done}
      if (i <= 4)      exp5 = 5'b00110;
      else if (i == 5) exp5 = 5'b00011;
      else if (i == 6) exp5 = 5'b10000;
      else             exp5 = 5'b01010;
      check($sformatf("busy_rej%0d", i), {3'b0, cmd_ready, j, k, busy, done}, {3'b0, exp5});
      if (i < 7) step();
    end
    cmd_valid = 1'b0;
    step();
    step();
    step();
    check("busy_rej_end", {6'b0, cmd_ready, busy}, 8'b10);

    // Async reset mid-DRIVE of a toggle of length 6.
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 4'd6;
    step();
    cmd_valid = 1'b0;
    step();
    #2 rst = 1'b0;
    #1 check("async_rst", {1'b0, outs()}, {1'b0, 7'b1000000});
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) done_cnt++;
    end
    check("rst_no_done", 8'(done_cnt), 8'd0);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd1;
    rst = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("post_rst_accept", {5'b0, busy, j, k}, 8'b110);
    step();
    check("post_rst_done", {6'b0, done, err}, 8'b10);
    step();
    check("post_rst_idle", {6'b0, cmd_ready, err}, 8'b10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
